// File: rtl/div_seq_if.sv
// div_seq_if: start/ready handshake and operand/result bus for the div_seq divider.
//   calc  : start request (master -> slave)
//   a     : 2W-bit dividend (master -> slave)
//   b     : W-bit divisor (master -> slave)
//   q     : 2W-bit quotient (slave -> master)
//   r     : W-bit remainder (slave -> master)
//   busy  : operation in progress (slave -> master)
//   rdy   : one-cycle completion pulse (slave -> master)
//   dz    : divide-by-zero flag (slave -> master)
interface div_seq_if #(
    parameter int unsigned W = 8
);
    logic             calc;
    logic [2*W-1:0]   a;
    logic [W-1:0]     b;
    logic [2*W-1:0]   q;
    logic [W-1:0]     r;
    logic             busy;
    logic             rdy;
    logic             dz;

    modport master (
        output calc, a, b,
        input  q, r, busy, rdy, dz
    );

    modport slave (
        input  calc, a, b,
        output q, r, busy, rdy, dz
    );
endinterface

// File: rtl/div_seq.sv
// div_seq: sequential unsigned restoring divider, one quotient bit per clock.
// Divides a 2W-bit dividend by a W-bit divisor giving a 2W-bit quotient and a
// W-bit remainder. A calc pulse in IDLE or DONE starts an operation; rdy pulses
// for one cycle when q/r are updated (17 clocks of latency for W=8).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : div_seq_if.slave (calc, a, b in; q, r, busy, rdy, dz out)
// Optional feature macro: DIV_SEQ_DZ_CHK_EN
//   defined   : b==0 skips the iterations, completes next cycle with dz=1
//   undefined : dz tied to 0, b==0 runs the full iteration sequence
module div_seq #(
    parameter int unsigned W = 8
) (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);
    localparam int unsigned DW = 2 * W;
    localparam int unsigned CW = $clog2(DW);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          r_state;
    state_e          w_state_nx;
    state_e          w_start_st;

    logic [DW-1:0]   r_dvd;
    logic [DW-1:0]   r_quo;
    logic [DW-1:0]   r_q;
    logic [W-1:0]    r_dvs;
    logic [W-1:0]    r_r;
    logic [W:0]      r_pr;
    logic [CW-1:0]   r_cnt;

    logic            w_accept;
    logic            w_last;
    logic [W:0]      w_pr_sh;
    logic            w_ge;
    logic [W:0]      w_pr_nx;
    logic [DW-1:0]   w_quo_nx;

    // Operations are accepted in IDLE and DONE; calc during RUN is ignored.
    assign w_accept = bus.calc && (r_state != StRun);
    assign w_last   = (r_state == StRun) && (r_cnt == CW'(DW - 1));

    // One restoring step: bring in the next dividend bit, trial-subtract.
    assign w_pr_sh  = {r_pr[W-1:0], r_dvd[DW-1]};
    assign w_ge     = (w_pr_sh >= {1'b0, r_dvs});
    assign w_pr_nx  = w_ge ? (w_pr_sh - {1'b0, r_dvs}) : w_pr_sh;
    assign w_quo_nx = {r_quo[DW-2:0], w_ge};

`ifdef DIV_SEQ_DZ_CHK_EN
    logic w_zero;
    logic r_dz;

    assign w_zero     = (bus.b == '0);
    assign w_start_st = w_zero ? StDone : StRun;
`else
    assign w_start_st = StRun;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_nx = w_start_st;
                end
            end
            StRun: begin
                if (w_last) begin
                    w_state_nx = StDone;
                end
            end
            StDone: begin
                w_state_nx = w_accept ? w_start_st : StIdle;
            end
            default: begin
                w_state_nx = StIdle;
            end
        endcase
    end

    // Datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd <= '0;
            r_dvs <= '0;
            r_pr  <= '0;
            r_quo <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_r   <= '0;
`ifdef DIV_SEQ_DZ_CHK_EN
            r_dz  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_dvd <= bus.a;
            r_dvs <= bus.b;
            r_pr  <= '0;
            r_quo <= '0;
            r_cnt <= '0;
`ifdef DIV_SEQ_DZ_CHK_EN
            // Zero divisor completes immediately with the natural result.
            if (w_zero) begin
                r_q  <= '1;
                r_r  <= bus.a[W-1:0];
                r_dz <= 1'b1;
            end
`endif
        end else if (r_state == StRun) begin
            r_dvd <= r_dvd << 1;
            r_pr  <= w_pr_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 1'b1;
            // Results are published only at completion so q/r hold during RUN.
            if (w_last) begin
                r_q  <= w_quo_nx;
                r_r  <= w_pr_nx[W-1:0];
`ifdef DIV_SEQ_DZ_CHK_EN
                r_dz <= 1'b0;
`endif
            end
        end
    end

    assign bus.q    = r_q;
    assign bus.r    = r_r;
    assign bus.busy = (r_state == StRun);
    assign bus.rdy  = (r_state == StDone);
`ifdef DIV_SEQ_DZ_CHK_EN
    assign bus.dz   = r_dz;
`else
    assign bus.dz   = 1'b0;
`endif
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq (W=8).
// Covers reset state, several quotient/remainder vectors, latency and busy
// duration, divide-by-zero (both builds of DIV_SEQ_DZ_CHK_EN), calc ignored
// during RUN, reset abort, and back-to-back operation from DONE.
module tb_div_seq;
    localparam int unsigned W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    div_seq_if #(.W(W)) bus ();

    div_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive operands with calc high and let the accepting edge occur.
    task automatic start_op(input logic [15:0] ia, input logic [7:0] ib);
        @(negedge clk);
        bus.calc = 1'b1;
        bus.a    = ia;
        bus.b    = ib;
        @(posedge clk);
    endtask

    // Called right after the accepting edge. lat counts edges with the
    // accepting edge as 1; returns at the negedge where rdy is seen.
    task automatic wait_done(input bit hold, input int inj_at, input logic [15:0] ia,
                             input logic [7:0] ib, output int lat, output int busy_n,
                             output int moves);
        logic [15:0] q0;
        logic [7:0]  r0;
        @(negedge clk);
        if (!hold) bus.calc = 1'b0;
        lat    = 1;
        busy_n = 0;
        moves  = 0;
        q0     = bus.q;
        r0     = bus.r;
        while (!bus.rdy && lat < 60) begin
            if (bus.busy) busy_n++;
            if (bus.q !== q0 || bus.r !== r0) moves++;
            if (lat == inj_at) begin
                bus.calc = 1'b1;
                bus.a    = ia;
                bus.b    = ib;
            end else if (lat == inj_at + 1) begin
                bus.calc = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] ia, input logic [7:0] ib,
                          input int inj_at, input logic [15:0] eq, input logic [7:0] er,
                          input int elat, input int ebusy, input logic edz);
        int lat, busy_n, moves;
        start_op(ia, ib);
        wait_done(1'b0, inj_at, 16'd5, 8'd1, lat, busy_n, moves);
        check({tag, ".lat"}, lat, elat);
        check({tag, ".busy_cycles"}, busy_n, ebusy);
        check({tag, ".q"}, {16'd0, bus.q}, {16'd0, eq});
        check({tag, ".r"}, {24'd0, bus.r}, {24'd0, er});
        check({tag, ".dz"}, {31'd0, bus.dz}, {31'd0, edz});
        check({tag, ".qr_stable_in_run"}, moves, 0);
        @(negedge clk);
        check({tag, ".rdy_one_cycle"}, {31'd0, bus.rdy}, 32'd0);
        check({tag, ".q_hold"}, {16'd0, bus.q}, {16'd0, eq});
    endtask

    initial begin
        int lat, busy_n, moves, rdy_seen;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.calc = 1'b0;
        bus.a    = '0;
        bus.b    = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset.q", {16'd0, bus.q}, 32'd0);
        check("reset.r", {24'd0, bus.r}, 32'd0);
        check("reset.busy", {31'd0, bus.busy}, 32'd0);
        check("reset.rdy", {31'd0, bus.rdy}, 32'd0);
        check("reset.dz", {31'd0, bus.dz}, 32'd0);

        // Basic vectors.
        run_op("sq255", 16'd65025, 8'd255, -10, 16'd255, 8'd0, 17, 16, 1'b0);
        run_op("d1000_7", 16'd1000, 8'd7, -10, 16'd142, 8'd6, 17, 16, 1'b0);
        run_op("a_lt_b", 16'd100, 8'd200, -10, 16'd0, 8'd100, 17, 16, 1'b0);
        run_op("div1", 16'd65535, 8'd1, -10, 16'd65535, 8'd0, 17, 16, 1'b0);

        // Divide by zero.
`ifdef DIV_SEQ_DZ_CHK_EN
        run_op("dz", 16'd65535, 8'd0, -10, 16'd65535, 8'd255, 1, 0, 1'b1);
`else
        run_op("dz", 16'd65535, 8'd0, -10, 16'd65535, 8'd255, 17, 16, 1'b0);
`endif
        // dz clears on the next normal completion.
        run_op("after_dz", 16'd1234, 8'd10, -10, 16'd123, 8'd4, 17, 16, 1'b0);

        // calc during RUN with other operands is ignored.
        run_op("ignore", 16'd1000, 8'd7, 5, 16'd142, 8'd6, 17, 16, 1'b0);

        // Reset in the middle of an operation.
        start_op(16'd1000, 8'd3);
        @(negedge clk);
        bus.calc = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort.q", {16'd0, bus.q}, 32'd0);
        check("abort.r", {24'd0, bus.r}, 32'd0);
        check("abort.busy", {31'd0, bus.busy}, 32'd0);
        check("abort.rdy", {31'd0, bus.rdy}, 32'd0);
        rdy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rdy) rdy_seen++;
        end
        check("abort.no_rdy", rdy_seen, 0);
        run_op("post_abort", 16'd300, 8'd16, -10, 16'd18, 8'd12, 17, 16, 1'b0);

        // Back-to-back: calc held high so DONE accepts the next operation.
        start_op(16'd1000, 8'd7);
        wait_done(1'b1, -10, 16'd0, 8'd0, lat, busy_n, moves);
        check("b2b1.lat", lat, 17);
        check("b2b1.q", {16'd0, bus.q}, 32'd142);
        check("b2b1.r", {24'd0, bus.r}, 32'd6);
        bus.a = 16'd200;
        bus.b = 8'd3;
        @(posedge clk);
        wait_done(1'b0, -10, 16'd0, 8'd0, lat, busy_n, moves);
        check("b2b2.lat", lat, 17);
        check("b2b2.busy_cycles", busy_n, 16);
        check("b2b2.q", {16'd0, bus.q}, 32'd66);
        check("b2b2.r", {24'd0, bus.r}, 32'd2);
        @(negedge clk);
        check("b2b2.rdy_one_cycle", {31'd0, bus.rdy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Sequential restoring divider; the inverse companion of the team's shift-add `mult`.
- Takes a 2W-bit dividend (the width of a `mult` product) and a W-bit divisor. Produces a 2W-bit quotient and a W-bit remainder, one quotient bit per clock.
- Same start/ready handshake style as `mult`: a `calc` pulse starts an operation, a one-cycle `rdy` pulse ends it.
- Sits in arithmetic datapaths that recover factors or scale products back down.

Parameters:
- W, 8, divisor and remainder width; dividend and quotient are 2W bits. Legal for W >= 2.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- calc  in  1  start request, sampled on clk rising edge.
- a  in  2W  dividend; sampled only on the accepting edge.
- b  in  W  divisor; sampled only on the accepting edge.
- q  out  2W  quotient, registered.
- r  out  W  remainder, registered.
- busy  out  1  high while an operation is in progress.
- rdy  out  1  one-cycle completion pulse; q/r valid from this cycle on.
- dz  out  1  divide-by-zero flag (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; q=0, r=0, busy=0, rdy=0, dz=0; iteration counter=0. rst overrides everything, including an operation in progress; no rdy is produced for an aborted operation.
- States:
  - IDLE.
  - RUN: 2W iterations.
  - DONE: one cycle.
- IDLE/DONE with calc=1:
  - Latch a into the dividend shift register, b into the divisor register.
  - Clear the (W+1)-bit partial remainder and counter.
  - Go to RUN; busy=1 from the next cycle.
- A calc pulse in DONE is accepted, so back-to-back operations are possible; rdy still pulses for the finishing operation.
- calc while in RUN is ignored; latched operands are unaffected.
- RUN, each edge:
  - pr = {pr[W-1:0], dividend MSB}; shift the dividend left by 1.
  - If pr >= {1'b0,b}: pr = pr - b and quotient bit = 1, else quotient bit = 0. The bit is shifted into the quotient register LSB.
  - The counter increments; the iteration with counter = 2W-1 is the last.
- After the last iteration: q <= quotient register, r <= pr[W-1:0], rdy=1, busy=0, state=DONE.
- rdy is high for exactly one cycle. It rises after edge 2W+1 counted from the accepting edge: W=8 gives 17 clocks of latency.
- DONE with no calc: return to IDLE, rdy=0.
- q/r hold their values until the next completion; they do not change during RUN.
- Arithmetic: unsigned. q = floor(a/b), r = a mod b; always q*b + r == a.
- Divisor zero, natural result: every trial subtract succeeds, so q = all ones and r = a[W-1:0]. This is deterministic and must be matched by the model.
- a < b: q=0, r=a[W-1:0].

Optional Feature:
- Macro: DIV_SEQ_DZ_CHK_EN.
- Defined:
  - On an accepting edge with b==0, skip RUN and go straight to DONE.
  - rdy pulses on the next cycle (latency 1).
  - q = all ones, r = a[W-1:0], dz=1.
  - dz is registered and updated at every completion (1 for b==0, 0 otherwise); reset 0.
- Not defined:
  - dz is tied to 0.
  - b==0 runs the full 2W iterations and yields the same q/r values as above.

Test Plan:
- W=8, a=65025, b=255, calc pulse -> busy for 16 cycles, rdy one cycle 17 clocks after accept, q=255, r=0, dz=0.
- a=1000, b=7 -> q=142, r=6; a=100, b=200 -> q=0, r=100; a=65535, b=1 -> q=65535, r=0.
- a=65535, b=0:
  - with DIV_SEQ_DZ_CHK_EN: rdy 1 clock after accept, q=65535, r=255, dz=1.
  - without the macro: rdy after 17 clocks, same q/r, dz=0.
- Start a=1000, b=7; pulse calc with a=5, b=1 at cycle 5 -> ignored; result q=142, r=6.
- Start an operation, assert rst at cycle 8 for 1 cycle -> q=0, r=0, busy=0, no rdy. A new calc with a=300, b=16 -> q=18, r=12.
- calc held high through DONE with a=200, b=3 -> first result rdy, then the second op completes 17 clocks later with q=66, r=2.
